uart_cmd_ctrl: RTL

- Command interpreter between the UART receive/transmit cores and the internal register bus of the EyeTracker top level.
- Collects ASCII lines from the RX core, parses the `rd`, `wr`, `stop` and `start` commands, and sequences one register-bus access per command.
- Returns a short ASCII response through the TX core.
- Drives the camera-pipeline run enable.

---
 rtl/uart_cmd_ctrl_if.sv | 39 +++
 rtl/uart_cmd_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_ctrl_if
//  Purpose  : Bundles the UART RX/TX handshake, register bus and status
//             signals of the command controller. The master modport is the
//             controller side; the slave modport is the surrounding system.
//  Revision : 1.0  initial release
// ============================================================================
interface uart_cmd_ctrl_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  iRX_DE;
    logic [7:0]            iRX_DATA;
    logic                  oTX_DE;
    logic [7:0]            oTX_DATA;
    logic                  iTX_BUSY;
    logic [ADDR_WIDTH-1:0] oREG_ADDR;
    logic [DATA_WIDTH-1:0] oREG_WDATA;
    logic                  oREG_WE;
    logic                  oREG_RE;
    logic [DATA_WIDTH-1:0] iREG_RDATA;
    logic                  iREG_RVALID;
    logic                  oRUN;
    logic                  oERR;

    modport master (
        input  iRX_DE, iRX_DATA, iTX_BUSY, iREG_RDATA, iREG_RVALID,
        output oTX_DE, oTX_DATA, oREG_ADDR, oREG_WDATA, oREG_WE, oREG_RE,
               oRUN, oERR
    );

    modport slave (
        output iRX_DE, iRX_DATA, iTX_BUSY, iREG_RDATA, iREG_RVALID,
        input  oTX_DE, oTX_DATA, oREG_ADDR, oREG_WDATA, oREG_WE, oREG_RE,
               oRUN, oERR
    );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_cmd_ctrl
//  Purpose  : ASCII command interpreter between the UART cores and the
//             internal register bus. Understands "rd AAAA", "wr AAAA DD",
//             "stop" and "start", performs one bus access per command and
//             answers with "OK", "NG" or two hex digits, each ending in LF.
//  Revision : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LINE_MAX   = 16,
    parameter int TIMEOUT    = 255
) (
    input  wire logic        CLK,
    input  wire logic        RST_N,
    uart_cmd_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(LINE_MAX + 1);
    localparam int IDX_W = $clog2(LINE_MAX);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [7:0] c_bs    = 8'h08;
    localparam logic [7:0] c_lf    = 8'h0A;
    localparam logic [7:0] c_cr    = 8'h0D;
    localparam logic [7:0] c_space = 8'h20;
    localparam logic [7:0] c_tilde = 8'h7E;

    localparam logic [CNT_W-1:0] c_line_max = CNT_W'(LINE_MAX);
    localparam logic [TO_W-1:0]  c_timeout  = TO_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_COLLECT   = 3'd0,
        S_PARSE     = 3'd1,
        S_WRITE     = 3'd2,
        S_READ      = 3'd3,
        S_RD_WAIT   = 3'd4,
        S_RESP_HOLD = 3'd5,
        S_RESP_WAIT = 3'd6
    } state_t;

    // Returns {valid, nibble} for an ASCII hex digit.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
        else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, c[3:0] + 4'd9};
        else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    // Uppercase ASCII hex character for a nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    state_t           state_q,   state_d;
    logic [1:0]       rx_sync_q, rx_sync_d;
    logic             rx_prev_q, rx_prev_d;
    logic [7:0]       line_q [LINE_MAX];
    logic [7:0]       line_d [LINE_MAX];
    logic [CNT_W-1:0] count_q,   count_d;
    logic             ovf_q,     ovf_d;
    logic             tx_de_q,   tx_de_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic [7:0]       resp1_q,   resp1_d;
    logic [1:0]       resp_idx_q, resp_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic             we_q,      we_d;
    logic             re_q,      re_d;
    logic             run_q,     run_d;
    logic             err_q,     err_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;

    logic       w_rx_accept;
    logic [7:0] w_rx_byte;
    logic [4:0] w_h0, w_h1, w_h2, w_h3, w_h4, w_h5;
    logic       w_addr_ok, w_data_ok;
    logic [15:0] w_addr16;
    logic [7:0]  w_data8;
    logic [7:0]  w_rdata8;
    logic       w_cmd_rd, w_cmd_wr, w_cmd_stop, w_cmd_start;

    // Rising edge of the synchronized data-valid; only 7-bit characters are kept.
    always_comb begin
        rx_sync_d   = {rx_sync_q[0], bus.iRX_DE};
        rx_prev_d   = rx_sync_q[1];
        w_rx_accept = rx_sync_q[1] & ~rx_prev_q;
        w_rx_byte   = bus.iRX_DATA & 8'h7F;
        w_rdata8    = 8'(bus.iREG_RDATA);
    end

    // Command decoding from the line buffer at fixed character positions.
    always_comb begin
        w_h0 = hex_nib(line_q[3]);
        w_h1 = hex_nib(line_q[4]);
        w_h2 = hex_nib(line_q[5]);
        w_h3 = hex_nib(line_q[6]);
        w_h4 = hex_nib(line_q[8]);
        w_h5 = hex_nib(line_q[9]);
        w_addr_ok = w_h0[4] & w_h1[4] & w_h2[4] & w_h3[4];
        w_data_ok = w_h4[4] & w_h5[4];
        w_addr16  = {w_h0[3:0], w_h1[3:0], w_h2[3:0], w_h3[3:0]};
        w_data8   = {w_h4[3:0], w_h5[3:0]};
        w_cmd_rd  = (count_q == CNT_W'(7)) &&
                    (line_q[0] == 8'h72) && (line_q[1] == 8'h64) &&
                    (line_q[2] == c_space) && w_addr_ok;
        w_cmd_wr  = (count_q == CNT_W'(10)) &&
                    (line_q[0] == 8'h77) && (line_q[1] == 8'h72) &&
                    (line_q[2] == c_space) && w_addr_ok &&
                    (line_q[7] == c_space) && w_data_ok;
        w_cmd_stop  = (count_q == CNT_W'(4)) &&
                      (line_q[0] == 8'h73) && (line_q[1] == 8'h74) &&
                      (line_q[2] == 8'h6F) && (line_q[3] == 8'h70);
        w_cmd_start = (count_q == CNT_W'(5)) &&
                      (line_q[0] == 8'h73) && (line_q[1] == 8'h74) &&
                      (line_q[2] == 8'h61) && (line_q[3] == 8'h72) &&
                      (line_q[4] == 8'h74);
    end

    // Main sequencer: line collection, dispatch, bus access and response.
    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        tx_de_d    = tx_de_q;
        tx_data_d  = tx_data_q;
        resp1_d    = resp1_q;
        resp_idx_d = resp_idx_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        re_d       = 1'b0;
        run_d      = run_q;
        err_d      = 1'b0;
        to_cnt_d   = to_cnt_q;

        case (state_q)
            S_COLLECT: begin
                if (w_rx_accept) begin
                    if (w_rx_byte == c_bs) begin
                        if (count_q != '0) count_d = count_q - 1'b1;
                    end else if (w_rx_byte == c_lf || w_rx_byte == c_cr) begin
                        state_d = S_PARSE;
                    end else if (w_rx_byte >= c_space && w_rx_byte <= c_tilde) begin
                        if (count_q < c_line_max) begin
                            line_d[count_q[IDX_W-1:0]] = w_rx_byte;
                            count_d = count_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end

            S_PARSE: begin
                // The response path below is taken unless a bus access starts.
                tx_de_d    = 1'b1;
                resp_idx_d = 2'd0;
                state_d    = S_RESP_HOLD;
                tx_data_d  = 8'h4F;     // 'O'
                resp1_d    = 8'h4B;     // 'K'
                if (count_q == '0) begin
                    tx_de_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_COLLECT;
                end else if (ovf_q) begin
                    tx_data_d = 8'h4E;  // 'N'
                    resp1_d   = 8'h47;  // 'G'
                    err_d     = 1'b1;
                end else if (w_cmd_rd) begin
                    tx_de_d = 1'b0;
                    addr_d  = ADDR_WIDTH'(w_addr16);
                    re_d    = 1'b1;
                    state_d = S_READ;
                end else if (w_cmd_wr) begin
                    tx_de_d = 1'b0;
                    addr_d  = ADDR_WIDTH'(w_addr16);
                    wdata_d = DATA_WIDTH'(w_data8);
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end else if (w_cmd_stop) begin
                    run_d = 1'b0;
                end else if (w_cmd_start) begin
                    run_d = 1'b1;
                end else begin
                    tx_data_d = 8'h4E;
                    resp1_d   = 8'h47;
                    err_d     = 1'b1;
                end
            end

            S_WRITE: begin
                tx_de_d    = 1'b1;
                tx_data_d  = 8'h4F;
                resp1_d    = 8'h4B;
                resp_idx_d = 2'd0;
                state_d    = S_RESP_HOLD;
            end

            S_READ: begin
                to_cnt_d = '0;
                state_d  = S_RD_WAIT;
            end

            S_RD_WAIT: begin
                // Read data takes priority over an expiring timeout.
                if (bus.iREG_RVALID) begin
                    tx_de_d    = 1'b1;
                    tx_data_d  = hex_char(w_rdata8[7:4]);
                    resp1_d    = hex_char(w_rdata8[3:0]);
                    resp_idx_d = 2'd0;
                    state_d    = S_RESP_HOLD;
                end else if (to_cnt_q == c_timeout) begin
                    tx_de_d    = 1'b1;
                    tx_data_d  = 8'h4E;
                    resp1_d    = 8'h47;
                    resp_idx_d = 2'd0;
                    err_d      = 1'b1;
                    state_d    = S_RESP_HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            S_RESP_HOLD: begin
                if (bus.iTX_BUSY) begin
                    tx_de_d = 1'b0;
                    state_d = S_RESP_WAIT;
                end
            end

            S_RESP_WAIT: begin
                if (!bus.iTX_BUSY) begin
                    case (resp_idx_q)
                        2'd0: begin
                            tx_data_d  = resp1_q;
                            tx_de_d    = 1'b1;
                            resp_idx_d = 2'd1;
                            state_d    = S_RESP_HOLD;
                        end
                        2'd1: begin
                            tx_data_d  = c_lf;
                            tx_de_d    = 1'b1;
                            resp_idx_d = 2'd2;
                            state_d    = S_RESP_HOLD;
                        end
                        default: begin
                            count_d = '0;
                            ovf_d   = 1'b0;
                            state_d = S_COLLECT;
                        end
                    endcase
                end
            end

            default: state_d = S_COLLECT;
        endcase
    end

    // Control and output registers with asynchronous reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_COLLECT;
            rx_sync_q  <= 2'b00;
            rx_prev_q  <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_de_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            resp1_q    <= 8'h00;
            resp_idx_q <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            run_q      <= 1'b1;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_prev_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_de_q    <= tx_de_d;
            tx_data_q  <= tx_data_d;
            resp1_q    <= resp1_d;
            resp_idx_q <= resp_idx_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            re_q       <= re_d;
            run_q      <= run_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    // Line storage needs no reset; the character count marks valid entries.
    always_ff @(posedge CLK) begin
        line_q <= line_d;
    end

    assign bus.oTX_DE     = tx_de_q;
    assign bus.oTX_DATA   = tx_data_q;
    assign bus.oREG_ADDR  = addr_q;
    assign bus.oREG_WDATA = wdata_q;
    assign bus.oREG_WE    = we_q;
    assign bus.oREG_RE    = re_q;
    assign bus.oRUN       = run_q;
    assign bus.oERR       = err_q;

endmodule
`default_nettype wire
